// File: rtl/sumador_serial.sv
// sumador_serial: bit-serial adder computing {cout,sum} = a + b + cin.
// One full-adder cell handles one bit per clock, LSB first, and the carry is
// held in a register between bits. An addition takes WIDTH RUN cycles plus
// one DONE cycle.
//
// Ports:
//   clk    - clock, all state changes on its rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request a new addition (sampled only in IDLE)
//   a, b   - WIDTH-bit operands, captured together with start
//   cin    - carry-in, captured together with start
//   busy   - high while the addition is running (RUN)
//   done   - one-cycle pulse: sum/cout have just been updated (DONE)
//   sum    - WIDTH-bit result, held until the next completion
//   cout   - final carry-out, held until the next completion
module sumador_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  // Full-adder cell on the operand LSBs and the registered carry
  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_carry <= w_c;
          // Counter stops at LAST, so it never wraps inside an operation
          if (!w_last) r_cnt <= r_cnt + 1'b1;
          // Publish directly from the shift input so the last bit is included
          if (w_last) begin
            sum  <= {w_s, r_res[WIDTH-1:1]};
            cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sumador_serial.md
SUMADOR_SERIAL -- requirements
Module: sumador_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, sampled with start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, sampled with start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress (state RUN).
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that sum and cout have just been updated.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result, held until the next completion.
REQ-011 The block SHALL have port cout, output, 1 bit: final carry-out, held until the next completion.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using one 1-bit full-adder cell per cycle and a registered carry.
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL capture a and b into internal shift registers, load the carry register with cin, clear the bit counter, and go to RUN.
REQ-015 Each RUN cycle SHALL do the following:
- add the shift-register LSBs and the carry register;
- shift the result bit into the MSB of an internal result shift register;
- shift both operand registers right by one;
- update the carry register;
- increment the counter.
REQ-016 On the edge that processes bit WIDTH-1, the block SHALL load sum from the result shift register (including that bit), load cout from the new carry, and go to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency SHALL be fixed: start sampled at edge k gives done=1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 edges after the sampling edge.
REQ-019 busy SHALL be 1 exactly in RUN.
REQ-020 done and busy SHALL never both be 1.
REQ-021 start SHALL be ignored in RUN and DONE. Operands changing during RUN SHALL NOT affect the result.
REQ-022 start held high continuously SHALL launch a new addition on the first edge in IDLE after DONE, giving back-to-back operations every WIDTH+2 cycles.
REQ-023 sum and cout SHALL change only on the edge entering DONE (or on reset). They SHALL keep their previous values during RUN.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.
REQ-025 Overflow SHALL be reported only via cout. sum SHALL be the result modulo 2^WIDTH.

Reset
REQ-026 While rst_n=0, the block SHALL immediately (no clock needed) force:
- state = IDLE;
- busy = 0, done = 0;
- sum = 0, cout = 0;
- carry register, counter and shift registers = 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse. The first start sampled after release SHALL run a complete, correct addition.
REQ-028 After rst_n deasserts, start SHALL be honoured on the first rising edge.

Verification (WIDTH=8)
REQ-029 Scenario: a=0x0F, b=0x01, cin=0, start for 1 cycle -> busy for 8 cycles, then done for 1 cycle with sum=0x10, cout=0.
REQ-030 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 Scenario: full sweep of the eight {cin,a[0],b[0]} combinations with the upper bits 0, matching the full-adder truth table -> sum[0] and sum[1] match a+b+cin.
REQ-032 Scenario: pulse start again and change a/b during RUN -> no restart; result equals the originally captured operands; exactly one done pulse.
REQ-033 Scenario: assert rst_n=0 at bit 4 of an operation -> outputs are 0 immediately and there is no done pulse. Then a=0x55, b=0xAA, cin=1 -> sum=0x00, cout=1.
REQ-034 Scenario: start held high for 3 operations -> done pulses spaced exactly 10 cycles apart, each result correct.
